// File: rtl/pio_pattern_sequencer_if.sv
// ----------------------------------------------------------------------------
// pio_pattern_sequencer_if
// Bundles the two Avalon-MM faces of the PIO pattern sequencer.
//   s_*  : CPU-facing slave (register/pattern access, zero wait states)
//   m_*  : PIO-facing master (writes to PIO data register, offset 0)
//   irq  : level interrupt towards the CPU
// Modports:
//   slave  : the sequencer's view (it is a slave peripheral to the CPU and
//            drives the PIO master port)
//   master : the surrounding system's view (CPU, fabric and PIO)
// ----------------------------------------------------------------------------
interface pio_pattern_sequencer_if;
    logic [4:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;

    logic [1:0]  m_address;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    logic        irq;

    modport slave (
        input  s_address, s_chipselect, s_write_n, s_writedata, m_waitrequest,
        output s_readdata, m_address, m_write_n, m_writedata, irq
    );

    modport master (
        output s_address, s_chipselect, s_write_n, s_writedata, m_waitrequest,
        input  s_readdata, m_address, m_write_n, m_writedata, irq
    );
endinterface

// File: rtl/pio_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// pio_pattern_sequencer
// Plays a table of DEPTH pattern words out to a PIO data register through an
// Avalon-MM master, holding each word for DWELL clock cycles, optionally
// looping, and raising a level IRQ when a non-looping sequence finishes.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous, active-low reset
//   bus      : slave modport of pio_pattern_sequencer_if
//              (CPU register slave, PIO master, irq)
// Register map (word address):
//   0 CTRL   : bit0 RUN, bit1 LOOP, bit2 IRQ_EN
//   1 STATUS : bit0 BUSY (RO), bit1 DONE (W1C), bits[11:8] index (RO)
//   2 DWELL  : dwell cycles (0 stores 1)
//   3 LENGTH : entries to play (0 stores 1, >DEPTH stores DEPTH)
//   16..16+DEPTH-1 : pattern entries
// ----------------------------------------------------------------------------
module pio_pattern_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DW      = 16,
    parameter int DWELL_W = 24
) (
    input  logic clk,
    input  logic reset_n,
    pio_pattern_sequencer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, DWELL} state_t;

    state_t               state_reg, state_next;
    logic                 run_reg, loop_reg, irq_en_reg, done_reg;
    logic [DWELL_W-1:0]   dwell_reg, counter_reg, counter_next;
    logic [LW-1:0]        length_reg;
    logic [IW-1:0]        index_reg, index_next;
    logic [DW-1:0]        wdata_reg;
    logic [DW-1:0]        pattern_mem [DEPTH];

    logic                 load_data, set_done, clear_run;

    // ------------------------------------------------------------------
    // Slave decode
    // ------------------------------------------------------------------
    logic                 wr_en, ctrl_wr, status_wr, dwell_wr, length_wr, pat_sel;
    logic [IW-1:0]        pat_idx;
    logic [LW-1:0]        length_clamped;
    logic [DWELL_W-1:0]   dwell_clamped;

    assign wr_en     = bus.s_chipselect & ~bus.s_write_n;
    assign ctrl_wr   = wr_en && (bus.s_address == 5'd0);
    assign status_wr = wr_en && (bus.s_address == 5'd1);
    assign dwell_wr  = wr_en && (bus.s_address == 5'd2);
    assign length_wr = wr_en && (bus.s_address == 5'd3);
    assign pat_sel   = bus.s_address[4] && (int'(bus.s_address[3:0]) < DEPTH);
    assign pat_idx   = bus.s_address[IW-1:0];

    always_comb begin
        length_clamped = bus.s_writedata[LW-1:0];
        if (bus.s_writedata == 32'd0) begin
            length_clamped = LW'(1);
        end else if (bus.s_writedata > 32'(DEPTH)) begin
            length_clamped = LW'(DEPTH);
        end
    end

    assign dwell_clamped = (bus.s_writedata[DWELL_W-1:0] == '0) ?
                           DWELL_W'(1) : bus.s_writedata[DWELL_W-1:0];

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        counter_next = counter_reg;
        load_data    = 1'b0;
        set_done     = 1'b0;
        clear_run    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run_reg) begin
                    state_next = WRITE;
                    index_next = '0;
                    load_data  = 1'b1;
                end
            end
            WRITE: begin
                // The master write is held until accepted; a RUN clear only
                // takes effect once the transfer is done.
                if (!bus.m_waitrequest) begin
                    if (!run_reg) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DWELL;
                        counter_next = dwell_reg;
                    end
                end
            end
            DWELL: begin
                if (counter_reg == DWELL_W'(1)) begin
                    if (!run_reg) begin
                        state_next = IDLE;
                    end else if (({1'b0, index_reg} + LW'(1)) < length_reg) begin
                        state_next = WRITE;
                        index_next = index_reg + IW'(1);
                        load_data  = 1'b1;
                    end else if (loop_reg) begin
                        state_next = WRITE;
                        index_next = '0;
                        load_data  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        set_done   = 1'b1;
                        clear_run  = 1'b1;
                    end
                end else begin
                    counter_next = counter_reg - DWELL_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            counter_reg <= '0;
            wdata_reg   <= '0;
            run_reg     <= 1'b0;
            loop_reg    <= 1'b0;
            irq_en_reg  <= 1'b0;
            done_reg    <= 1'b0;
            dwell_reg   <= DWELL_W'(1);
            length_reg  <= LW'(DEPTH);
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            counter_reg <= counter_next;

            // The pattern is captured when the entry is fetched, so a CPU
            // update of that entry shows up on its next fetch.
            if (load_data) begin
                wdata_reg <= pattern_mem[index_next];
            end

            // Completion clears RUN even if the CPU writes CTRL on that edge.
            if (clear_run) begin
                run_reg <= 1'b0;
            end else if (ctrl_wr) begin
                run_reg <= bus.s_writedata[0];
            end
            if (ctrl_wr) begin
                loop_reg   <= bus.s_writedata[1];
                irq_en_reg <= bus.s_writedata[2];
            end

            // Setting DONE wins over a simultaneous write-1-to-clear.
            if (set_done) begin
                done_reg <= 1'b1;
            end else if (status_wr && bus.s_writedata[1]) begin
                done_reg <= 1'b0;
            end

            if (dwell_wr) begin
                dwell_reg <= dwell_clamped;
            end
            if (length_wr) begin
                length_reg <= length_clamped;
            end
        end
    end

    // Pattern storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && pat_sel) begin
            pattern_mem[pat_idx] <= bus.s_writedata[DW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Slave read mux (combinational, zero wait states)
    // ------------------------------------------------------------------
    always_comb begin
        bus.s_readdata = '0;
        case (bus.s_address)
            5'd0: bus.s_readdata[2:0] = {irq_en_reg, loop_reg, run_reg};
            5'd1: begin
                bus.s_readdata[0]      = (state_reg != IDLE);
                bus.s_readdata[1]      = done_reg;
                bus.s_readdata[8 +: IW] = index_reg;
            end
            5'd2: bus.s_readdata[DWELL_W-1:0] = dwell_reg;
            5'd3: bus.s_readdata[LW-1:0]      = length_reg;
            default: begin
                if (pat_sel) begin
                    bus.s_readdata[DW-1:0] = pattern_mem[pat_idx];
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Master and interrupt outputs
    // ------------------------------------------------------------------
    assign bus.m_address   = 2'b00;
    assign bus.m_write_n   = (state_reg != WRITE);
    assign bus.m_writedata = 32'(wdata_reg);
    assign bus.irq         = done_reg & irq_en_reg;

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pio_pattern_sequencer
// Randomized self-checking bench for pio_pattern_sequencer. A bus monitor
// records every master write (start cycle, accept cycle, data); expected
// data and timing are derived from the loaded table and the dwell rules.
// ----------------------------------------------------------------------------
module tb_pio_pattern_sequencer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_wr_cyc = 0;

    pio_pattern_sequencer_if bus();

    pio_pattern_sequencer #(.DEPTH(DEPTH), .DW(16), .DWELL_W(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Master-side monitor
    // ------------------------------------------------------------------
    int          start_q[$];
    int          acc_q[$];
    logic [31:0] data_q[$];
    bit          in_wr = 1'b0;
    logic [31:0] cur_data;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_wr = 1'b0;
        end else if (!bus.m_write_n) begin
            if (!in_wr) begin
                in_wr = 1'b1;
                start_q.push_back(cyc);
                cur_data = bus.m_writedata;
                check("m_address", 32'(bus.m_address), 32'd0);
            end else begin
                check("hold_data", bus.m_writedata, cur_data);
            end
            if (!bus.m_waitrequest) begin
                acc_q.push_back(cyc);
                data_q.push_back(bus.m_writedata);
                in_wr = 1'b0;
                $display("[TB] master write data=%h cyc=%0d", bus.m_writedata, cyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Waitrequest driver
    // ------------------------------------------------------------------
    bit stall_force = 1'b0;
    bit stall_rand  = 1'b0;

    initial begin
        bus.m_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_waitrequest = stall_force || (stall_rand && ($urandom_range(0, 3) == 0));
        end
    end

    // ------------------------------------------------------------------
    // CPU access tasks
    // ------------------------------------------------------------------
    task automatic cpu_write(input int addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        bus.s_address    = 5'(addr);
        bus.s_writedata  = data;
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        last_wr_cyc      = cyc;
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
    endtask

    task automatic cpu_read(input int addr, output logic [31:0] data);
        @(posedge clk);
        #1;
        bus.s_address    = 5'(addr);
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b1;
        @(negedge clk);
        data = bus.s_readdata;
        bus.s_chipselect = 1'b0;
    endtask

    task automatic wait_acc(input int n, input string tag);
        for (int i = 0; i < 2000 && acc_q.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_start(input int n, input string tag);
        for (int i = 0; i < 2000 && start_q.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 32'(start_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] rd;
        rd = 32'h1;
        for (int i = 0; i < 2000 && rd[0]; i++) begin
            cpu_read(1, rd);
        end
        check(tag, 32'(rd[0]), 32'd0);
    endtask

    task automatic clear_mon();
        start_q.delete();
        acc_q.delete();
        data_q.delete();
    endtask

    // ------------------------------------------------------------------
    // One non-looping sequence, checked against the table and dwell rules
    // ------------------------------------------------------------------
    logic [15:0] pat_m [DEPTH];

    task automatic run_seq(input int len, input int dwell, input bit irq_en, input bit directed_stall);
        logic [31:0] rd;
        int t0;
        for (int i = 0; i < len; i++) begin
            cpu_write(16 + i, {16'($urandom), pat_m[i]});
        end
        cpu_read(16, rd);
        check("pat_readback", rd, {16'h0, pat_m[0]});
        cpu_write(3, 32'(len));
        cpu_write(2, 32'(dwell));
        clear_mon();
        cpu_write(0, {29'h0, irq_en, 1'b0, 1'b1});
        t0 = last_wr_cyc;
        if (directed_stall) begin
            wait_acc(1, "stall_first_acc");
            stall_force = 1'b1;
            wait_start(2, "stall_second_start");
            repeat (2) @(negedge clk);
            stall_force = 1'b0;
        end
        wait_idle("seq_idle");
        check("n_writes", 32'(acc_q.size()), 32'(len));
        check("n_starts", 32'(start_q.size()), 32'(len));
        if (start_q.size() > 0) begin
            check("first_latency", 32'(start_q[0]), 32'(t0 + 1));
        end
        for (int k = 0; k < len && k < acc_q.size(); k++) begin
            check("wr_data", data_q[k], {16'h0, pat_m[k]});
            if (k > 0) begin
                check("wr_spacing", 32'(start_q[k]), 32'(acc_q[k-1] + dwell + 1));
            end
        end
        if (directed_stall && acc_q.size() > 1) begin
            check("stall_len", 32'(acc_q[1] - start_q[1]), 32'd3);
        end
        cpu_read(1, rd);
        check("status_done", rd, (32'(len - 1) << 8) | 32'h2);
        check("irq_done", 32'(bus.irq), 32'(irq_en));
        cpu_read(0, rd);
        check("ctrl_after", rd, {29'h0, irq_en, 2'b00});
        cpu_write(1, 32'h2);
        cpu_read(1, rd);
        check("status_w1c", rd, 32'(len - 1) << 8);
        check("irq_cleared", 32'(bus.irq), 32'd0);
        $display("[TB] sequence len=%0d dwell=%0d irq_en=%0d writes=%0d", len, dwell, irq_en, acc_q.size());
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] rd;
        int n_open;

        bus.s_address    = '0;
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
        bus.s_writedata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_write_n", 32'(bus.m_write_n), 32'd1);
        check("rst_irq", 32'(bus.irq), 32'd0);
        check("rst_wdata", bus.m_writedata, 32'd0);
        reset_n = 1'b1;
        cpu_read(1, rd); check("rst_status", rd, 32'd0);
        cpu_read(3, rd); check("rst_length", rd, 32'd8);
        cpu_read(2, rd); check("rst_dwell", rd, 32'd1);
        cpu_read(0, rd); check("rst_ctrl", rd, 32'd0);

        // Unmapped addresses
        cpu_write(5, 32'hDEADBEEF);
        cpu_read(5, rd); check("unmapped_5", rd, 32'd0);
        cpu_write(31, 32'h1234);
        cpu_read(31, rd); check("unmapped_31", rd, 32'd0);

        // Basic three-entry sequence, then again with a 3-cycle stall
        pat_m[0] = 16'h0001; pat_m[1] = 16'h0002; pat_m[2] = 16'h0004;
        run_seq(3, 4, 1'b1, 1'b0);
        run_seq(3, 4, 1'b1, 1'b1);

        // Clamping
        cpu_write(3, 32'd0);  cpu_read(3, rd); check("clamp_len0", rd, 32'd1);
        cpu_write(3, 32'd20); cpu_read(3, rd); check("clamp_len20", rd, 32'd8);
        cpu_write(2, 32'd0);  cpu_read(2, rd); check("clamp_dwell0", rd, 32'd1);
        pat_m[0] = 16'hBEEF;
        run_seq(1, 1, 1'b1, 1'b0);

        // Randomized sequences under random back-pressure
        stall_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) pat_m[i] = 16'($urandom);
            run_seq($urandom_range(1, DEPTH), $urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'b0);
        end
        stall_rand = 1'b0;

        // Looping two-entry sequence, stopped during a stalled write
        cpu_write(16, 32'hAAAA);
        cpu_write(17, 32'h5555);
        cpu_write(3, 32'd2);
        cpu_write(2, 32'd1);
        clear_mon();
        cpu_write(0, 32'h3);
        n_open = last_wr_cyc;
        wait_acc(6, "loop_acc6");
        stall_force = 1'b1;
        for (int i = 0; i < 100 && start_q.size() <= acc_q.size(); i++) begin
            @(negedge clk);
            #1;
        end
        check("loop_open_write", 32'(start_q.size() > acc_q.size()), 32'd1);
        cpu_write(0, 32'h2);
        n_open = (start_q.size() > 0) ? start_q.size() : n_open;
        repeat (3) @(negedge clk);
        stall_force = 1'b0;
        wait_idle("loop_idle");
        check("loop_n_acc", 32'(acc_q.size()), 32'(n_open));
        check("loop_n_start", 32'(start_q.size()), 32'(n_open));
        for (int k = 0; k < acc_q.size(); k++) begin
            check("loop_data", data_q[k], (k % 2 == 1) ? 32'h5555 : 32'hAAAA);
            if (k > 0) check("loop_spacing", 32'(start_q[k]), 32'(acc_q[k-1] + 2));
        end
        cpu_read(1, rd);
        check("loop_no_done", 32'(rd[1]), 32'd0);
        check("loop_write_n", 32'(bus.m_write_n), 32'd1);
        cpu_read(0, rd);
        check("loop_ctrl", rd, 32'h2);

        // Asynchronous reset during a stalled master write
        cpu_write(3, 32'd2);
        cpu_write(2, 32'd3);
        clear_mon();
        stall_force = 1'b1;
        cpu_write(0, 32'h5);
        wait_start(1, "arst_start");
        @(negedge clk);
        check("arst_write_low", 32'(bus.m_write_n), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_write_n", 32'(bus.m_write_n), 32'd1);
        check("arst_irq", 32'(bus.irq), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stall_force = 1'b0;
        cpu_read(0, rd); check("arst_ctrl", rd, 32'd0);
        cpu_read(1, rd); check("arst_status", rd, 32'd0);
        cpu_read(3, rd); check("arst_length", rd, 32'd8);
        repeat (5) @(negedge clk);
        check("arst_stays_idle", 32'(bus.m_write_n), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
